hv_efuse_load_ctrl: RTL and testbench



---
 rtl/hv_efuse_load_ctrl_if.sv | 49 ++++
 rtl/hv_efuse_load_ctrl.sv | 178 +++++++++++++++++
 tb/tb_hv_efuse_load_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hv_efuse_load_ctrl_if.sv
// Bundles the efuse load controller's request/response, efuse macro and register-file signals.
// The master modport is the controller side; the slave modport is the environment side.
interface hv_efuse_load_ctrl_if #(
    parameter int EFUSE_ADDR_W = 3,
    parameter int EFUSE_DATA_W = 8
) ();
    logic                    i_pwr_on;
    logic                    i_efuse_load_req;
    logic                    o_efuse_load_done;
    logic                    o_efuse_vld;
    logic                    o_efuse_busy;
    logic                    o_efuse_pwr_en;
    logic [EFUSE_ADDR_W-1:0] o_efuse_addr;
    logic                    o_efuse_rd_en;
    logic [EFUSE_DATA_W-1:0] i_efuse_dout;
    logic                    o_reg_wr_en;
    logic [EFUSE_ADDR_W-1:0] o_reg_wr_addr;
    logic [EFUSE_DATA_W-1:0] o_reg_wr_data;

    modport master (
        input  i_pwr_on,
        input  i_efuse_load_req,
        input  i_efuse_dout,
        output o_efuse_load_done,
        output o_efuse_vld,
        output o_efuse_busy,
        output o_efuse_pwr_en,
        output o_efuse_addr,
        output o_efuse_rd_en,
        output o_reg_wr_en,
        output o_reg_wr_addr,
        output o_reg_wr_data
    );

    modport slave (
        output i_pwr_on,
        output i_efuse_load_req,
        output i_efuse_dout,
        input  o_efuse_load_done,
        input  o_efuse_vld,
        input  o_efuse_busy,
        input  o_efuse_pwr_en,
        input  o_efuse_addr,
        input  o_efuse_rd_en,
        input  o_reg_wr_en,
        input  o_reg_wr_addr,
        input  o_reg_wr_data
    );
endinterface

// File: rtl/hv_efuse_load_ctrl.sv
// Efuse image loader for the HV control FSM: powers the macro, copies all words into the register file
// and qualifies the image. Define HV_EFUSE_CRC_CHK_EN to treat the last word as an XOR checksum.
module hv_efuse_load_ctrl #(
    parameter int EFUSE_WORD_NUM = 8,
    parameter int EFUSE_ADDR_W   = 3,
    parameter int EFUSE_DATA_W   = 8,
    parameter int PWR_SETUP_CYC  = 4,
    parameter int RD_PULSE_CYC   = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    hv_efuse_load_ctrl_if.master   efuse_if
);
    localparam int CYC_MAX = (PWR_SETUP_CYC > RD_PULSE_CYC) ? PWR_SETUP_CYC : RD_PULSE_CYC;
    localparam int CYC_W   = (CYC_MAX < 2) ? 1 : $clog2(CYC_MAX);
    localparam logic [CYC_W-1:0]        PWR_LAST  = CYC_W'(PWR_SETUP_CYC - 1);
    localparam logic [CYC_W-1:0]        RD_LAST   = CYC_W'(RD_PULSE_CYC - 1);
    localparam logic [EFUSE_ADDR_W-1:0] WORD_LAST = EFUSE_ADDR_W'(EFUSE_WORD_NUM - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PWR_UP = 3'd1,
        ADDR   = 3'd2,
        STRB   = 3'd3,
        CAPT   = 3'd4,
        CHK    = 3'd5,
        DONE   = 3'd6
    } state_t;

    state_t                  state_q;
    logic [CYC_W-1:0]        cyc_q;
    logic [EFUSE_ADDR_W-1:0] cnt_q;
    logic                    prog_q;
    logic                    done_q;
    logic                    vld_q;
    logic                    busy_q;
    logic                    pwr_en_q;
    logic [EFUSE_ADDR_W-1:0] addr_q;
    logic                    rd_en_q;
    logic                    wr_en_q;
    logic [EFUSE_ADDR_W-1:0] wr_addr_q;
    logic [EFUSE_DATA_W-1:0] wr_data_q;
`ifdef HV_EFUSE_CRC_CHK_EN
    logic [EFUSE_DATA_W-1:0] acc_q;
`endif

    // Load sequencer; every output is a register updated together with the state.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            cyc_q     <= '0;
            cnt_q     <= '0;
            prog_q    <= 1'b0;
            done_q    <= 1'b0;
            vld_q     <= 1'b0;
            busy_q    <= 1'b0;
            pwr_en_q  <= 1'b0;
            addr_q    <= '0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
`ifdef HV_EFUSE_CRC_CHK_EN
            acc_q     <= '0;
`endif
        end else if ((state_q != IDLE) && !efuse_if.i_pwr_on) begin
            // Supply loss: abandon the load silently and drop the image-valid flag.
            state_q  <= IDLE;
            done_q   <= 1'b0;
            vld_q    <= 1'b0;
            busy_q   <= 1'b0;
            pwr_en_q <= 1'b0;
            rd_en_q  <= 1'b0;
            wr_en_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (!efuse_if.i_pwr_on) begin
                        vld_q <= 1'b0;
                    end else if (efuse_if.i_efuse_load_req) begin
                        state_q  <= PWR_UP;
                        busy_q   <= 1'b1;
                        pwr_en_q <= 1'b1;
                        vld_q    <= 1'b0;
                        cnt_q    <= '0;
                        cyc_q    <= '0;
`ifdef HV_EFUSE_CRC_CHK_EN
                        acc_q    <= '0;
`endif
                    end else begin
                        state_q <= IDLE;
                    end
                end
                PWR_UP: begin
                    if (cyc_q == PWR_LAST) begin
                        state_q <= ADDR;
                        addr_q  <= cnt_q;
                    end else begin
                        cyc_q <= cyc_q + 1'b1;
                    end
                end
                ADDR: begin
                    state_q <= STRB;
                    rd_en_q <= 1'b1;
                    cyc_q   <= '0;
                end
                STRB: begin
                    if (cyc_q == RD_LAST) begin
                        state_q   <= CAPT;
                        rd_en_q   <= 1'b0;
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= cnt_q;
                        wr_data_q <= efuse_if.i_efuse_dout;
                        if (cnt_q == '0) begin
                            prog_q <= efuse_if.i_efuse_dout[EFUSE_DATA_W-1];
                        end else begin
                            prog_q <= prog_q;
                        end
`ifdef HV_EFUSE_CRC_CHK_EN
                        // The checksum word itself stays out of the running XOR.
                        if (cnt_q != WORD_LAST) begin
                            acc_q <= acc_q ^ efuse_if.i_efuse_dout;
                        end else begin
                            acc_q <= acc_q;
                        end
`endif
                    end else begin
                        cyc_q <= cyc_q + 1'b1;
                    end
                end
                CAPT: begin
                    wr_en_q <= 1'b0;
                    if (cnt_q == WORD_LAST) begin
                        state_q  <= CHK;
                        pwr_en_q <= 1'b0;
                    end else begin
                        state_q <= ADDR;
                        cnt_q   <= cnt_q + 1'b1;
                        addr_q  <= cnt_q + 1'b1;
                    end
                end
                CHK: begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
`ifdef HV_EFUSE_CRC_CHK_EN
                    vld_q   <= prog_q & (acc_q == wr_data_q);
`else
                    vld_q   <= prog_q;
`endif
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q  <= IDLE;
                    done_q   <= 1'b0;
                    busy_q   <= 1'b0;
                    pwr_en_q <= 1'b0;
                    rd_en_q  <= 1'b0;
                    wr_en_q  <= 1'b0;
                end
            endcase
        end
    end

    assign efuse_if.o_efuse_load_done = done_q;
    assign efuse_if.o_efuse_vld       = vld_q;
    assign efuse_if.o_efuse_busy      = busy_q;
    assign efuse_if.o_efuse_pwr_en    = pwr_en_q;
    assign efuse_if.o_efuse_addr      = addr_q;
    assign efuse_if.o_efuse_rd_en     = rd_en_q;
    assign efuse_if.o_reg_wr_en       = wr_en_q;
    assign efuse_if.o_reg_wr_addr     = wr_addr_q;
    assign efuse_if.o_reg_wr_data     = wr_data_q;
endmodule

// File: tb/tb_hv_efuse_load_ctrl.sv
// Directed bench for hv_efuse_load_ctrl: a small efuse array model answers reads, and every
// register write, done pulse and strobe cycle is logged on the falling clock edge.
module tb_hv_efuse_load_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [7:0] fuse_mem [8];
    int         wr_cnt;
    int         done_cnt;
    int         pwr_cyc;
    int         rd_cyc;
    logic [2:0] wr_addr_log [16];
    logic [7:0] wr_data_log [16];
    int         lat;
    logic [7:0] xsum;

    hv_efuse_load_ctrl_if #(.EFUSE_ADDR_W(3), .EFUSE_DATA_W(8)) bus ();

    hv_efuse_load_ctrl #(
        .EFUSE_WORD_NUM(8),
        .EFUSE_ADDR_W  (3),
        .EFUSE_DATA_W  (8),
        .PWR_SETUP_CYC (4),
        .RD_PULSE_CYC  (2)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .efuse_if(bus.master)
    );

    assign bus.i_efuse_dout = fuse_mem[bus.o_efuse_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        wr_cnt   = 0;
        done_cnt = 0;
        pwr_cyc  = 0;
        rd_cyc   = 0;
    endtask

    task automatic sample();
        if (bus.o_reg_wr_en === 1'b1) begin
            if (wr_cnt < 16) begin
                wr_addr_log[wr_cnt] = bus.o_reg_wr_addr;
                wr_data_log[wr_cnt] = bus.o_reg_wr_data;
            end
            wr_cnt++;
        end
        if (bus.o_efuse_load_done === 1'b1) done_cnt++;
        if (bus.o_efuse_pwr_en === 1'b1) pwr_cyc++;
        if (bus.o_efuse_rd_en === 1'b1) rd_cyc++;
    endtask

    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            sample();
        end
    endtask

    // Returns the falling-edge index (1 = first cycle after the request was sampled) of the done pulse, 0 on timeout.
    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            sample();
            if (bus.o_efuse_load_done === 1'b1) begin
                cyc = n;
                break;
            end
        end
    endtask

    task automatic check_writes(input string tag);
        for (int i = 0; i < 8; i++) begin
            chk({tag, "_wr_addr"}, {29'd0, wr_addr_log[i]}, i);
            chk({tag, "_wr_data"}, {24'd0, wr_data_log[i]}, {24'd0, fuse_mem[i]});
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clear_logs();
        rst_n = 1'b0;
        bus.i_pwr_on = 1'b0;
        bus.i_efuse_load_req = 1'b0;
        fuse_mem[0] = 8'h80;
        for (int i = 1; i < 8; i++) fuse_mem[i] = 8'(i);

        // Reset state
        run_cycles(2);
        chk("rst_done",    {31'd0, bus.o_efuse_load_done}, 32'd0);
        chk("rst_vld",     {31'd0, bus.o_efuse_vld},       32'd0);
        chk("rst_busy",    {31'd0, bus.o_efuse_busy},      32'd0);
        chk("rst_pwr_en",  {31'd0, bus.o_efuse_pwr_en},    32'd0);
        chk("rst_rd_en",   {31'd0, bus.o_efuse_rd_en},     32'd0);
        chk("rst_wr_en",   {31'd0, bus.o_reg_wr_en},       32'd0);
        chk("rst_addr",    {29'd0, bus.o_efuse_addr},      32'd0);
        chk("rst_wr_addr", {29'd0, bus.o_reg_wr_addr},     32'd0);
        chk("rst_wr_data", {24'd0, bus.o_reg_wr_data},     32'd0);
        rst_n = 1'b1;
        bus.i_pwr_on = 1'b1;
        run_cycles(2);

        // Nominal load, request held through DONE and dropped one cycle later
        clear_logs();
        bus.i_efuse_load_req = 1'b1;
        run_cycles(1);
        chk("t1_busy_c1",   {31'd0, bus.o_efuse_busy},   32'd1);
        chk("t1_pwr_en_c1", {31'd0, bus.o_efuse_pwr_en}, 32'd1);
        wait_done(60, lat);
        lat = lat + 1;
        chk("t1_latency", lat, 32'd38);
        chk("t1_vld_at_done", {31'd0, bus.o_efuse_vld}, 32'd1);
        chk("t1_busy_at_done", {31'd0, bus.o_efuse_busy}, 32'd1);
        run_cycles(1);
        chk("t1_done_after", {31'd0, bus.o_efuse_load_done}, 32'd0);
        chk("t1_busy_after", {31'd0, bus.o_efuse_busy}, 32'd0);
        bus.i_efuse_load_req = 1'b0;
        run_cycles(10);
        chk("t1_wr_cnt",   wr_cnt, 32'd8);
        chk("t1_done_cnt", done_cnt, 32'd1);
        chk("t1_pwr_cyc",  pwr_cyc, 32'd36);
        chk("t1_rd_cyc",   rd_cyc, 32'd16);
        chk("t1_vld_hold", {31'd0, bus.o_efuse_vld}, 32'd1);
        chk("t1_idle_busy", {31'd0, bus.o_efuse_busy}, 32'd0);
        check_writes("t1");

        // Unprogrammed image: load completes but image is not valid
        clear_logs();
        fuse_mem[0] = 8'h00;
        bus.i_efuse_load_req = 1'b1;
        run_cycles(1);
        chk("t2_vld_cleared", {31'd0, bus.o_efuse_vld}, 32'd0);
        wait_done(60, lat);
        lat = lat + 1;
        bus.i_efuse_load_req = 1'b0;
        chk("t2_latency", lat, 32'd38);
        chk("t2_vld", {31'd0, bus.o_efuse_vld}, 32'd0);
        run_cycles(3);
        chk("t2_wr_cnt", wr_cnt, 32'd8);
        chk("t2_done_cnt", done_cnt, 32'd1);

        // Checksum word: good then corrupted
        fuse_mem[0] = 8'h80;
        fuse_mem[1] = 8'h11;
        fuse_mem[2] = 8'h22;
        fuse_mem[3] = 8'h33;
        fuse_mem[4] = 8'h44;
        fuse_mem[5] = 8'h55;
        fuse_mem[6] = 8'h66;
        xsum = 8'h00;
        for (int i = 0; i < 7; i++) xsum = xsum ^ fuse_mem[i];
        chk("t3_xsum_model", {24'd0, xsum}, 32'h0000_00F7);
        fuse_mem[7] = xsum;
        clear_logs();
        bus.i_efuse_load_req = 1'b1;
        wait_done(60, lat);
        bus.i_efuse_load_req = 1'b0;
        chk("t3_good_vld", {31'd0, bus.o_efuse_vld}, 32'd1);
        run_cycles(3);
        check_writes("t3g");
        fuse_mem[7] = xsum ^ 8'h01;
        clear_logs();
        bus.i_efuse_load_req = 1'b1;
        wait_done(60, lat);
        bus.i_efuse_load_req = 1'b0;
`ifdef HV_EFUSE_CRC_CHK_EN
        chk("t3_bad_vld", {31'd0, bus.o_efuse_vld}, 32'd0);
`else
        chk("t3_bad_vld", {31'd0, bus.o_efuse_vld}, 32'd1);
`endif
        run_cycles(3);
        chk("t3_bad_wr_cnt", wr_cnt, 32'd8);
        chk("t3_bad_last_data", {24'd0, wr_data_log[7]}, {24'd0, xsum ^ 8'h01});

        // Supply loss during the third word's read strobe
        fuse_mem[7] = xsum;
        clear_logs();
        bus.i_efuse_load_req = 1'b1;
        wait_done(60, lat);
        bus.i_efuse_load_req = 1'b0;
        run_cycles(2);
        chk("t4_pre_vld", {31'd0, bus.o_efuse_vld}, 32'd1);
        clear_logs();
        bus.i_efuse_load_req = 1'b1;
        run_cycles(14);
        chk("t4_in_strb_rd",   {31'd0, bus.o_efuse_rd_en}, 32'd1);
        chk("t4_in_strb_addr", {29'd0, bus.o_efuse_addr},  32'd2);
        bus.i_pwr_on = 1'b0;
        run_cycles(1);
        chk("t4_rd_en",  {31'd0, bus.o_efuse_rd_en},  32'd0);
        chk("t4_pwr_en", {31'd0, bus.o_efuse_pwr_en}, 32'd0);
        chk("t4_busy",   {31'd0, bus.o_efuse_busy},   32'd0);
        chk("t4_vld",    {31'd0, bus.o_efuse_vld},    32'd0);
        bus.i_efuse_load_req = 1'b0;
        run_cycles(45);
        chk("t4_wr_cnt",   wr_cnt, 32'd2);
        chk("t4_done_cnt", done_cnt, 32'd0);
        bus.i_pwr_on = 1'b1;
        run_cycles(2);

        // Reset pulse during power-up, then a fresh load with the request still high
        bus.i_efuse_load_req = 1'b1;
        run_cycles(2);
        chk("t5_in_pwrup", {31'd0, bus.o_efuse_pwr_en}, 32'd1);
        rst_n = 1'b0;
        run_cycles(1);
        chk("t5_rst_busy",   {31'd0, bus.o_efuse_busy},   32'd0);
        chk("t5_rst_pwr_en", {31'd0, bus.o_efuse_pwr_en}, 32'd0);
        chk("t5_rst_vld",    {31'd0, bus.o_efuse_vld},    32'd0);
        chk("t5_rst_addr",   {29'd0, bus.o_efuse_addr},   32'd0);
        rst_n = 1'b1;
        clear_logs();
        wait_done(60, lat);
        bus.i_efuse_load_req = 1'b0;
        chk("t5_latency", lat, 32'd38);
        chk("t5_vld", {31'd0, bus.o_efuse_vld}, 32'd1);
        run_cycles(3);
        chk("t5_wr_cnt", wr_cnt, 32'd8);
        chk("t5_done_cnt", done_cnt, 32'd1);
        check_writes("t5");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
